// File: rtl/icache_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// slave: the cache itself; master: the fetcher/memory-controller side.
interface icache_if;
  logic [31:0] fetch_pc;
  logic        fetch_able;
  logic        clear;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  fetch_pc, fetch_able, clear, mem_ready, mem_data,
    output ins_out, ins_pc, ins_ready, mem_req, mem_addr
  );

  modport master (
    output fetch_pc, fetch_able, clear, mem_ready, mem_data,
    input  ins_out, ins_pc, ins_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache for RV32IC fetch.
// Reads two consecutive words per lookup so a 32-bit instruction that
// straddles a word boundary is assembled in one cycle once both lines are
// present. Missing lines are refilled one word at a time (A before B).
// Optional build macro ICACHE_STAT_EN adds hit_cnt / miss_cnt outputs.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  icache_if.slave     bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [31:0] ins_q, ins_d, pc_q, pc_d, addr_q, addr_d;
  logic        out_valid_q, out_valid_d, req_q, req_d, fill;

  // Two read ports: A at word w, B at word w+1 (index wraps, tag from w+1).
  logic [29:0]           wa, wb;
  logic [INDEX_BITS-1:0] ia, ib, fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [31:0]           word_a;
  logic [15:0]           b_lo, lo;
  logic                  hit_a, hit_b, need_b, hit;
  logic [31:0]           ins_asm, miss_addr;
  logic                  unused_bits;

  assign wa     = bus.fetch_pc[31:2];
  assign wb     = wa + 30'd1;
  assign ia     = wa[INDEX_BITS-1:0];
  assign ib     = wb[INDEX_BITS-1:0];
  assign hit_a  = valid_q[ia] && (tag_q[ia] == wa[29:INDEX_BITS]);
  assign hit_b  = valid_q[ib] && (tag_q[ib] == wb[29:INDEX_BITS]);
  assign word_a = data_q[ia];
  assign b_lo   = data_q[ib][15:0];
  assign lo     = bus.fetch_pc[1] ? word_a[31:16] : word_a[15:0];

  // Only an upper-half 32-bit instruction needs the next word.
  assign need_b    = (lo[1:0] == 2'b11) && bus.fetch_pc[1];
  assign hit       = hit_a && (!need_b || hit_b);
  assign miss_addr = hit_a ? {wb, 2'b00} : {wa, 2'b00};

  // Instruction assembly: compressed, aligned 32-bit, or straddling 32-bit.
  always_comb begin
    ins_asm = {16'b0, lo};
    if (lo[1:0] == 2'b11)
      ins_asm = bus.fetch_pc[1] ? {b_lo, word_a[31:16]} : word_a;
  end

  assign fill_idx    = addr_q[INDEX_BITS+1:2];
  assign fill_tag    = addr_q[31:INDEX_BITS+2];
  assign unused_bits = ^{bus.fetch_pc[0], addr_q[1:0]};

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    req_d       = req_q;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.fetch_able || bus.clear) begin
          out_valid_d = 1'b0;
        end else if (hit) begin
          ins_d       = ins_asm;
          pc_d        = {bus.fetch_pc[31:1], 1'b0};
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
          addr_d      = miss_addr;
          req_d       = 1'b1;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        // A flush here does not abort; the line still lands in the array.
        out_valid_d = 1'b0;
        if (bus.mem_ready) begin
          fill    = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers and valid bits; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      ins_q       <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      req_q       <= req_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: valid bits guard them.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_data;
    end
  end

`ifdef ICACHE_STAT_EN
  // Lookup statistics: hits load out_valid, misses enter REFILL.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in) begin
      if (state_q == IDLE && out_valid_d) hit_cnt <= hit_cnt + 32'd1;
      if (state_q == IDLE && state_d == REFILL) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

  assign bus.ins_out   = ins_q;
  assign bus.ins_pc    = pc_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.ins_ready = out_valid_q && (pc_q[31:1] == bus.fetch_pc[31:1]) &&
                         bus.fetch_able && !bus.clear;
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a memory responder answers refills three
// cycles after mem_req, a table of fetches is checked against a scoreboard,
// and hand-written sequences cover timing, flush, reset and index wrap.
module tb_icache;
  logic clk = 1'b0;
  logic rst, rdy;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  int   ready_cyc = 0;
  logic [31:0] req_log [$];

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;
  exp_t sb [$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          nreq;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;
  vec_t vt [10];

  icache_if bus ();

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache #(.INDEX_BITS(6)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: return 32'h00500093;
      32'h004: return 32'h00100113;
      32'h008: return 32'h45050001;
      32'h010: return 32'h00930001;
      32'h014: return 32'h12340050;
      32'h024: return 32'h00c58533;
      32'h028: return 32'h05130002;
      32'h02C: return 32'hBEEF0010;
      32'h030: return 32'h00000013;
      32'h034: return 32'h00200113;
      32'h040: return 32'h00300193;
      32'h0FC: return 32'h05130001;
      32'h100: return 32'h000000A0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Memory controller model: log the request, answer 3 cycles later
  // unless reset arrives in the meantime.
  initial begin : responder
    logic [31:0] ra;
    bit abort;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        ra = bus.mem_addr;
        req_log.push_back(ra);
        abort = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          bus.mem_data  = mem_word(ra);
          bus.mem_ready = 1'b1;
          ready_cyc     = cyc;
          @(negedge clk);
          bus.mem_ready = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic wait_ready(input int max, input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.ins_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s: ins_ready not seen within %0d cycles", nm, max);
    end
  endtask

  // Fetch pc, wait for the instruction, compare against the scoreboard and
  // against the refill requests the memory model saw.
  task automatic do_fetch(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                          input int nreq, input logic [31:0] a0, input logic [31:0] a1);
    int   base;
    bit   ok;
    exp_t e;
    base = req_log.size();
    sb.push_back('{ins: ins, pc: {pc[31:1], 1'b0}});
    bus.fetch_pc   = pc;
    bus.fetch_able = 1'b1;
    wait_ready(60, nm, ok);
    e = sb.pop_front();
    if (ok) begin
      chk({nm, " ins_out"}, bus.ins_out, e.ins);
      chk({nm, " ins_pc"}, bus.ins_pc, e.pc);
    end
    chk({nm, " refills"}, req_log.size() - base, nreq);
    if (nreq > 0 && req_log.size() > base) chk({nm, " addr0"}, req_log[base], a0);
    if (nreq > 1 && req_log.size() > base + 1) chk({nm, " addr1"}, req_log[base+1], a1);
    bus.fetch_able = 1'b0;
    @(negedge clk);
  endtask

  initial begin : main
    int   base;
    bit   ok;
    exp_t e;

    vt[0] = '{32'h0A, 32'h00004505, 1, 32'h08, 32'h0};
    vt[1] = '{32'h08, 32'h00000001, 0, 32'h0,  32'h0};
    vt[2] = '{32'h12, 32'h00500093, 2, 32'h10, 32'h14};
    vt[3] = '{32'h10, 32'h00000001, 0, 32'h0,  32'h0};
    vt[4] = '{32'h16, 32'h00001234, 0, 32'h0,  32'h0};
    vt[5] = '{32'h24, 32'h00c58533, 1, 32'h24, 32'h0};
    vt[6] = '{32'h26, 32'h000000c5, 0, 32'h0,  32'h0};
    vt[7] = '{32'h28, 32'h00000002, 1, 32'h28, 32'h0};
    vt[8] = '{32'h2A, 32'h00100513, 1, 32'h2C, 32'h0};
    vt[9] = '{32'h04, 32'h00100113, 1, 32'h04, 32'h0};

    rst = 1'b1;
    rdy = 1'b1;
    bus.fetch_pc   = '0;
    bus.fetch_able = 1'b0;
    bus.clear      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ins_out", bus.ins_out, 32'h0);
    chk("reset ins_pc", bus.ins_pc, 32'h0);
    chk("reset ins_ready", {31'b0, bus.ins_ready}, 32'h0);
    chk("reset mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss with exact request and return timing.
    sb.push_back('{ins: 32'h00500093, pc: 32'h0});
    bus.fetch_pc   = 32'h0;
    bus.fetch_able = 1'b1;
    @(negedge clk);
    chk("cold mem_req", {31'b0, bus.mem_req}, 32'h1);
    chk("cold mem_addr", bus.mem_addr, 32'h0);
    wait_ready(30, "cold", ok);
    e = sb.pop_front();
    if (ok) begin
      chk("cold ready latency", cyc - ready_cyc, 2);
      chk("cold ins_out", bus.ins_out, e.ins);
      chk("cold ins_pc", bus.ins_pc, e.pc);
    end

    // Hit timing: stall on 0x4, then present 0x0 and expect it next cycle.
    bus.fetch_able = 1'b0;
    bus.fetch_pc   = 32'h4;
    @(negedge clk);
    chk("stall ins_ready", {31'b0, bus.ins_ready}, 32'h0);
    base = req_log.size();
    bus.fetch_pc   = 32'h0;
    bus.fetch_able = 1'b1;
    chk("hit same-cycle ins_ready", {31'b0, bus.ins_ready}, 32'h0);
    @(negedge clk);
    chk("hit ins_ready", {31'b0, bus.ins_ready}, 32'h1);
    chk("hit ins_out", bus.ins_out, 32'h00500093);
    @(negedge clk);
    chk("hit held ins_ready", {31'b0, bus.ins_ready}, 32'h1);
    chk("hit no refill", req_log.size() - base, 0);

    // rdy_in low freezes the lookup.
    bus.fetch_able = 1'b0;
    @(negedge clk);
    rdy = 1'b0;
    bus.fetch_able = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("pause ins_ready", {31'b0, bus.ins_ready}, 32'h0);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("resume ins_ready", {31'b0, bus.ins_ready}, 32'h1);
    bus.fetch_able = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      do_fetch($sformatf("vec%0d", i), vt[i].pc, vt[i].ins, vt[i].nreq, vt[i].a0, vt[i].a1);

    // Flush in IDLE suppresses the request for an uncached line.
    base = req_log.size();
    bus.fetch_pc   = 32'h30;
    bus.fetch_able = 1'b1;
    bus.clear      = 1'b1;
    repeat (3) @(negedge clk);
    chk("clear idle mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("clear idle no refill", req_log.size() - base, 0);
    bus.clear      = 1'b0;
    bus.fetch_able = 1'b0;
    @(negedge clk);

    // Flush one cycle into a refill: request held, line still written.
    base = req_log.size();
    bus.fetch_pc   = 32'h34;
    bus.fetch_able = 1'b1;
    @(negedge clk);
    chk("flush mem_req", {31'b0, bus.mem_req}, 32'h1);
    bus.clear = 1'b1;
    @(negedge clk);
    chk("flush held mem_req", {31'b0, bus.mem_req}, 32'h1);
    chk("flush ins_ready", {31'b0, bus.ins_ready}, 32'h0);
    bus.clear = 1'b0;
    @(negedge clk);
    chk("flush mem_req pre-ready", {31'b0, bus.mem_req}, 32'h1);
    bus.fetch_able = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush one refill", req_log.size() - base, 1);
    do_fetch("flush refetch", 32'h34, 32'h00200113, 0, 32'h0, 32'h0);

    // Reset during a refill drops the request.
    bus.fetch_pc   = 32'h40;
    bus.fetch_able = 1'b1;
    @(negedge clk);
    chk("rst-refill mem_req", {31'b0, bus.mem_req}, 32'h1);
    rst = 1'b1;
    bus.fetch_able = 1'b0;
    @(negedge clk);
    chk("rst-refill mem_req dropped", {31'b0, bus.mem_req}, 32'h0);
    chk("rst-refill mem_addr", bus.mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Index wrap: 0xFE straddles into 0x100 (index 0, tag 1).
    do_fetch("wrap", 32'hFE, 32'h00A00513, 2, 32'hFC, 32'h100);
`ifdef ICACHE_STAT_EN
    chk("wrap miss_cnt", miss_cnt, 32'd2);
    chk("wrap hit_cnt", hit_cnt, 32'd1);
`endif
    do_fetch("wrap line hit", 32'h100, 32'h000000A0, 0, 32'h0, 32'h0);
    do_fetch("wrap tag conflict", 32'h0, 32'h00500093, 1, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
